// File: rtl/config_frame_pkg.sv
// Shared FSM state type and elaboration-time mapping helpers for config_frame_mem.
package config_frame_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_e;

    // Frames needed to cover every exported config bit.
    function automatic int calc_nf(input int no_bits, input int frame_bits);
        return (no_bits + frame_bits - 1) / frame_bits;
    endfunction

    // Flat ConfigBits index of frame f, bit b; -1 when the bit falls below bit 0.
    function automatic int cfg_index(input int f, input int b, input int no_bits, input int frame_bits);
        int idx;
        idx = no_bits - 1 - (f * frame_bits + frame_bits - 1 - b);
        return (idx < 0) ? -1 : idx;
    endfunction

endpackage

// File: rtl/config_frame_map.sv
// Combinational scatter (frame word -> flat mask/bits) and gather (flat vector -> frame word)
// between frame-addressed words and the flat ConfigBits layout.
module config_frame_map
    import config_frame_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 88,
    parameter int FrameAddrW      = 5
) (
    input  logic [FrameAddrW-1:0]      i_wr_frame,
    input  logic [FrameBitsPerRow-1:0] i_wr_word,
    output logic [NoConfigBits-1:0]    o_wr_mask,
    output logic [NoConfigBits-1:0]    o_wr_bits,
    input  logic [FrameAddrW-1:0]      i_rd_frame,
    input  logic [NoConfigBits-1:0]    i_rd_flat,
    output logic [FrameBitsPerRow-1:0] o_rd_word
);

    localparam int NF   = calc_nf(NoConfigBits, FrameBitsPerRow);
    localparam int IdxW = (NoConfigBits > 1) ? $clog2(NoConfigBits) : 1;

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loops so no path can infer a latch.
        o_wr_mask = '0;
        o_wr_bits = '0;
        o_rd_word = '0;
        idx       = 0;
        for (int f = 0; f < NF; f++) begin
            for (int b = 0; b < FrameBitsPerRow; b++) begin
                idx = cfg_index(f, b, NoConfigBits, FrameBitsPerRow);
                if (idx >= 0) begin
                    if (i_wr_frame == FrameAddrW'(f)) begin
                        o_wr_mask[idx[IdxW-1:0]] = 1'b1;
                        o_wr_bits[idx[IdxW-1:0]] = i_wr_word[b];
                    end
                    if (i_rd_frame == FrameAddrW'(f)) begin
                        o_rd_word[b] = i_rd_flat[idx[IdxW-1:0]];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/config_frame_mem.sv
// Double-buffered tile configuration memory: frames load a shadow bank, commit copies it atomically
// to the active bank. Define CONFIG_FRAME_MEM_READBACK_EN to enable active-bank readback.
module config_frame_mem
    import config_frame_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 88,
    localparam int FrameAddrW     = $clog2(MaxFramesPerCol),
    localparam int PendW          = $clog2(MaxFramesPerCol + 1)
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [FrameAddrW-1:0]      wr_frame,
    input  logic [FrameBitsPerRow-1:0] wr_data,
    output logic                       wr_err,
    input  logic                       commit,
    output logic                       commit_done,
    output logic                       commit_err,
    output logic [PendW-1:0]           frames_pending,
    input  logic                       rd_req,
    input  logic [FrameAddrW-1:0]      rd_frame,
    output logic                       rd_valid,
    output logic [FrameBitsPerRow-1:0] rd_data,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N
);

    localparam int NF = calc_nf(NoConfigBits, FrameBitsPerRow);

    state_e                     r_state;
    logic [NoConfigBits-1:0]    r_shadow;
    logic [NoConfigBits-1:0]    r_active;
    logic [NF-1:0]              r_written;
    logic                       r_wr_err;
    logic                       r_commit_done;
    logic                       r_commit_err;

    logic                       w_wr_fire;
    logic                       w_wr_in_range;
    logic                       w_commit_req;
    logic [PendW-1:0]           w_pending;
    logic [NoConfigBits-1:0]    w_wr_mask;
    logic [NoConfigBits-1:0]    w_wr_bits;
    logic [FrameAddrW-1:0]      w_rd_frame;
    logic [NoConfigBits-1:0]    w_rd_flat;
    logic [FrameBitsPerRow-1:0] w_rd_word;

    assign w_pending     = PendW'(NF) - PendW'($countones(r_written));
    // A pending commit request blocks writes so the copied shadow is exactly what was checked.
    assign wr_ready      = (r_state == ST_IDLE) && !commit;
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = ({1'b0, wr_frame} < (FrameAddrW + 1)'(NF));
    assign w_commit_req  = (r_state == ST_IDLE) && commit;

    config_frame_map #(
        .FrameBitsPerRow (FrameBitsPerRow),
        .NoConfigBits    (NoConfigBits),
        .FrameAddrW      (FrameAddrW)
    ) u_map (
        .i_wr_frame (wr_frame),
        .i_wr_word  (wr_data),
        .o_wr_mask  (w_wr_mask),
        .o_wr_bits  (w_wr_bits),
        .i_rd_frame (w_rd_frame),
        .i_rd_flat  (w_rd_flat),
        .o_rd_word  (w_rd_word)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            // NOTE: both banks are reset so ConfigBits is defined as soon as resetn asserts.
            r_shadow <= '0;
        end else if (w_wr_fire && w_wr_in_range) begin
            r_shadow <= (r_shadow & ~w_wr_mask) | (w_wr_bits & w_wr_mask);
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_active      <= '0;
            r_written     <= '0;
            r_wr_err      <= 1'b0;
            r_commit_done <= 1'b0;
            r_commit_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates mean a readback in the COMMIT cycle samples the old bank.
            r_wr_err      <= w_wr_fire && !w_wr_in_range;
            r_commit_err  <= w_commit_req && (w_pending != '0);
            r_commit_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_commit_req && (w_pending == '0)) begin
                        r_state <= ST_COMMIT;
                    end else if (w_wr_fire && w_wr_in_range) begin
                        for (int f = 0; f < NF; f++) begin
                            if (wr_frame == FrameAddrW'(f)) r_written[f] <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_active      <= r_shadow;
                    r_written     <= '0;
                    r_commit_done <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CONFIG_FRAME_MEM_READBACK_EN
    logic                       r_rd_valid;
    logic [FrameBitsPerRow-1:0] r_rd_data;

    assign w_rd_frame = rd_frame;
    assign w_rd_flat  = r_active;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) r_rd_data <= w_rd_word;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
`else
    logic w_unused_rd;

    // Constant gather inputs let synthesis strip the readback path entirely.
    assign w_rd_frame  = '0;
    assign w_rd_flat   = '0;
    assign w_unused_rd = ^{rd_req, rd_frame, w_rd_word};
    assign rd_valid    = 1'b0;
    assign rd_data     = '0;
`endif

    assign wr_err         = r_wr_err;
    assign commit_done    = r_commit_done;
    assign commit_err     = r_commit_err;
    assign frames_pending = w_pending;
    assign ConfigBits     = r_active;
    assign ConfigBits_N   = ~r_active;

endmodule

// File: tb/tb_config_frame_mem.sv
// Scoreboard bench for config_frame_mem: expected banks and readback words are queued at drive time
// and popped when commit_done / rd_valid appear.
module tb_config_frame_mem;

    localparam int MAXF = 20;
    localparam int FBR  = 32;
    localparam int NCB  = 88;
    localparam int NF   = 3;
    localparam int FAW  = $clog2(MAXF);
    localparam int PW   = $clog2(MAXF + 1);

    logic           CLK      = 1'b0;
    logic           resetn   = 1'b0;
    logic           wr_valid = 1'b0;
    logic           commit   = 1'b0;
    logic           rd_req   = 1'b0;
    logic [FAW-1:0] wr_frame = '0;
    logic [FAW-1:0] rd_frame = '0;
    logic [FBR-1:0] wr_data  = '0;
    logic           wr_ready, wr_err, commit_done, commit_err, rd_valid;
    logic [PW-1:0]  frames_pending;
    logic [FBR-1:0] rd_data;
    logic [NCB-1:0] ConfigBits, ConfigBits_N;

    config_frame_mem #(
        .MaxFramesPerCol (MAXF),
        .FrameBitsPerRow (FBR),
        .NoConfigBits    (NCB)
    ) dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_frame       (wr_frame),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .commit         (commit),
        .commit_done    (commit_done),
        .commit_err     (commit_err),
        .frames_pending (frames_pending),
        .rd_req         (rd_req),
        .rd_frame       (rd_frame),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .ConfigBits     (ConfigBits),
        .ConfigBits_N   (ConfigBits_N)
    );

    always #5 CLK = ~CLK;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [NCB-1:0] cfg_q[$];
    logic [FBR-1:0] rd_q[$];
    logic [FBR-1:0] m_frame[NF];
    logic [NF-1:0]  m_written;
    logic [NCB-1:0] m_active;
    logic [NCB-1:0] all_ones = '1;
    logic [NCB-1:0] mon_e, mon_en;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frames concatenated MSB-first; the exported bank is the top NCB bits of that word stream.
    function automatic logic [NCB-1:0] model_cfg();
        logic [NF*FBR-1:0] cat;
        for (int f = 0; f < NF; f++) cat[(NF-1-f)*FBR +: FBR] = m_frame[f];
        return cat[NF*FBR-1 -: NCB];
    endfunction

    function automatic logic [FBR-1:0] rd_model(input int frame);
        logic [NF*FBR-1:0] ext;
        if (frame >= NF) return '0;
        ext = {m_active, {(NF*FBR-NCB){1'b0}}};
        return ext[(NF-1-frame)*FBR +: FBR];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int frame, input logic [FBR-1:0] data);
        bit accepted = 1'b0;
        wr_valid = 1'b1;
        wr_frame = FAW'(frame);
        wr_data  = data;
        for (int i = 0; i < 8 && !accepted; i++) begin
            accepted = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        if (!accepted) begin
            check("wr_accept_timeout", wr_ready, 1);
        end else begin
            check($sformatf("wr_err_f%0d", frame), wr_err, (frame >= NF));
            if (frame < NF) begin
                m_frame[frame]   = data;
                m_written[frame] = 1'b1;
            end
            check("pending_after_wr", frames_pending, NF - $countones(m_written));
        end
    endtask

    task automatic do_read(input int frame);
        rd_req   = 1'b1;
        rd_frame = FAW'(frame);
`ifdef CONFIG_FRAME_MEM_READBACK_EN
        rd_q.push_back(rd_model(frame));
`endif
        tick();
        rd_req = 1'b0;
    endtask

    task automatic do_commit(input bit rd_in_commit);
        bit             ok = (m_written == '1);
        bit             seen = 1'b0;
        logic [NCB-1:0] nxt = model_cfg();
        commit = 1'b1;
        #1 check("wr_ready_commit_req", wr_ready, 0);
        if (ok) cfg_q.push_back(nxt);
        tick();
        commit = 1'b0;
        check("cfg_hold_after_req", ConfigBits, m_active);
        if (ok) begin
            if (rd_in_commit) begin
                rd_req   = 1'b1;
                rd_frame = '0;
`ifdef CONFIG_FRAME_MEM_READBACK_EN
                rd_q.push_back(rd_model(0));
`endif
            end
            for (int i = 0; i < 6 && !seen; i++) begin
                tick();
                rd_req = 1'b0;
                seen   = commit_done;
            end
            if (!seen) check("commit_done_timeout", commit_done, 1);
            m_active  = nxt;
            m_written = '0;
        end else begin
            check("commit_err", commit_err, 1);
            check("pending_refused", frames_pending, NF - $countones(m_written));
            tick();
            check("commit_err_pulse", commit_err, 0);
            check("cfg_after_refused", ConfigBits, m_active);
        end
    endtask

    always @(negedge CLK) begin
        if (commit_done) begin
            if (cfg_q.size() == 0) begin
                check("commit_done_unexpected", commit_done, 0);
            end else begin
                mon_e  = cfg_q.pop_front();
                mon_en = ~mon_e;
                check("cfg_bits", ConfigBits, mon_e);
                check("cfg_bits_n", ConfigBits_N, mon_en);
            end
        end
        if (rd_valid) begin
            if (rd_q.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
            else check("rd_data", rd_data, rd_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_frame   = '{default: '0};
        m_written = '0;
        m_active  = '0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_cfg", ConfigBits, 0);
        check("rst_cfg_n", ConfigBits_N, all_ones);
        check("rst_pending", frames_pending, NF);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_pulses", {wr_err, commit_done, commit_err, rd_valid}, 0);
        check("rst_rd_data", rd_data, 0);
        commit = 1'b1;
        #1 check("rst_wr_ready_commit", wr_ready, 0);
        commit = 1'b0;
        resetn = 1'b1;
        tick();

        // Normal load and commit
        do_write(0, 32'hFFFF_FFFF);
        do_write(1, 32'h0000_0000);
        do_write(2, 32'hA5A5_A5A5);
        do_commit(1'b0);
        check("cfg_87_56", ConfigBits[87:56], 32'hFFFF_FFFF);
        check("cfg_55_24", ConfigBits[55:24], 32'h0);
        check("cfg_23_0", ConfigBits[23:0], 24'hA5A5A5);

        // Readback, including an unused frame slot
        do_read(2);
        do_read(0);
        do_read(7);
        do_read(1);
        tick();
`ifndef CONFIG_FRAME_MEM_READBACK_EN
        check("rd_data_disabled", rd_data, 0);
`endif

        // Incomplete commit refused, then completed
        do_write(0, 32'h1111_1111);
        do_write(1, 32'h2222_2222);
        do_commit(1'b0);
        do_write(2, 32'h3333_3333);
        do_commit(1'b1);

        // Rewrites and out-of-range writes with a full shadow pending
        do_write(0, 32'h5555_AAAA);
        do_write(0, 32'hDEAD_BEEF);
        do_write(1, 32'h0BAD_F00D);
        do_write(2, 32'hCAFE_F00D);
        do_write(5, 32'h1234_5678);
        tick();
        check("wr_err_pulse", wr_err, 0);
        do_write(3, 32'hFFFF_FFFF);
        do_write(19, 32'h8765_4321);
        do_commit(1'b0);

        // Write/commit collision: commit wins, write retried afterwards
        do_write(0, 32'h0102_0304);
        do_write(1, 32'h0506_0708);
        do_write(2, 32'h090A_0B0C);
        wr_valid = 1'b1;
        wr_frame = '0;
        wr_data  = 32'hFFFF_0000;
        commit   = 1'b1;
        #1 check("wr_ready_collision", wr_ready, 0);
        cfg_q.push_back(model_cfg());
        m_active = model_cfg();
        tick();
        commit = 1'b0;
        check("wr_ready_in_commit", wr_ready, 0);
        tick();
        check("collision_done", commit_done, 1);
        check("wr_ready_after_commit", wr_ready, 1);
        m_written = '0;
        tick();
        wr_valid   = 1'b0;
        m_frame[0] = 32'hFFFF_0000;
        m_written[0] = 1'b1;
        check("pending_after_retry", frames_pending, 2);
        check("cfg_after_retry", ConfigBits, m_active);

        // Reset during COMMIT
        do_write(1, 32'h7777_7777);
        do_write(2, 32'h8888_8888);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        resetn = 1'b0;
        #1;
        check("rst_mid_cfg", ConfigBits, 0);
        check("rst_mid_cfg_n", ConfigBits_N, all_ones);
        check("rst_mid_pending", frames_pending, NF);
        check("rst_mid_wr_ready", wr_ready, 1);
        m_frame   = '{default: '0};
        m_written = '0;
        m_active  = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        do_commit(1'b0);

        tick();
        check("cfg_q_drained", cfg_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
